// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front-panel control slice.
// State encoding and default debounce length.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam int unsigned DB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability filter, and a
// single-cycle press pulse on each accepted 0->1 level change.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W     = 20
) (
    input  logic clk,
    input  logic clr_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = (sync != stable) && (cnt == CNT_LAST);
    assign level  = stable;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            stable    <= 1'b0;
            cnt       <= '0;
            press     <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync      <= sync_meta;
            if (sync == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Registered alongside the stable update so the FSM acts on the next edge.
            press <= accept & sync;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel control: debounced start/stop and reset buttons
// drive a run/pause FSM with registered go/clr/led outputs.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W     = 20
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       btn_go_raw,
    input  logic       btn_clr_raw,
    output logic       go,
    output logic       clr,
    output logic [1:0] state,
    output logic       led_run
);

    state_t state_q;
    state_t state_d;
    logic   go_press;
    logic   clr_press;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_go (
        .clk     (clk),
        .clr_n   (clr_n),
        .btn_raw (btn_go_raw),
        .level   (),
        .press   (go_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_clr (
        .clk     (clk),
        .clr_n   (clr_n),
        .btn_raw (btn_clr_raw),
        .level   (),
        .press   (clr_press)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go_press) state_d = ST_RUN;
            ST_RUN:   if (go_press) state_d = ST_PAUSE;
            ST_PAUSE: if (go_press) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
        if (clr_press) state_d = ST_IDLE;
    end

    // Outputs decode the next state so they update on the same edge as state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            go      <= 1'b0;
            led_run <= 1'b0;
            clr     <= 1'b1;
        end else begin
            state_q <= state_d;
            go      <= (state_d == ST_RUN);
            led_run <= (state_d == ST_RUN);
            clr     <= clr_press;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DB_CYCLES=4: expected output
// changes are queued with their edge number; a monitor matches each change.
module tb_stopwatch_ctrl;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       g;
        logic       c;
    } ev_t;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       btn_go_raw = 1'b0;
    logic       btn_clr_raw = 1'b0;
    logic       go;
    logic       clr;
    logic [1:0] state;
    logic       led_run;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    ev_t  q[$];
    logic [4:0] prev = 5'b00010;

    stopwatch_ctrl #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .btn_go_raw  (btn_go_raw),
        .btn_clr_raw (btn_clr_raw),
        .go          (go),
        .clr         (clr),
        .state       (state),
        .led_run     (led_run)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the output vector must match the queue head.
    always @(negedge clk) begin
        logic [4:0] cur;
        ev_t e;
        cur = {state, go, clr, led_run};
        if (mon_en && cur !== prev) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: cyc=%0d state=%b go=%b clr=%b led=%b, want no change",
                         cyc, state, go, clr, led_run);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || state !== e.st || go !== e.g || clr !== e.c || led_run !== e.g) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d state=%b go=%b clr=%b led=%b, want cyc=%0d state=%b go=%b clr=%b led=%b",
                             cyc, state, go, clr, led_run, e.cyc, e.st, e.g, e.c, e.g);
                end
            end
            prev = cur;
        end
    end

    task automatic expect_ev(input int c, input logic [1:0] st, input logic g, input logic cl);
        ev_t e;
        e.cyc = c; e.st = st; e.g = g; e.c = cl;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic release_and_settle();
        repeat (10) step();
        btn_go_raw  = 1'b0;
        btn_clr_raw = 1'b0;
        repeat (10) step();
    endtask

    task automatic clean_go(input logic [1:0] st_exp, input logic go_exp);
        step();
        btn_go_raw = 1'b1;
        expect_ev(cyc + 7, st_exp, go_exp, 1'b0);
        release_and_settle();
    endtask

    int m;

    initial begin
        #1 clr_n = 1'b0;
        #1;
        chk("reset_clr_async", int'(clr), 1);
        repeat (3) step();
        chk("reset_clr", int'(clr), 1);
        chk("reset_go", int'(go), 0);
        chk("reset_state", int'(state), 0);
        chk("reset_led", int'(led_run), 0);
        clr_n  = 1'b0;
        clr_n  = 1'b1;
        mon_en = 1'b1;
        expect_ev(cyc + 1, 2'b00, 1'b0, 1'b0);
        repeat (5) step();

        // Start: IDLE -> RUN
        clean_go(2'b01, 1'b1);

        // Bounce 1,0,1,0 then hold: one transition RUN -> PAUSE after final rise
        step(); btn_go_raw = 1'b1;
        step(); btn_go_raw = 1'b0;
        step(); btn_go_raw = 1'b1;
        step(); btn_go_raw = 1'b0;
        step(); btn_go_raw = 1'b1;
        expect_ev(cyc + 7, 2'b10, 1'b0, 1'b0);
        release_and_settle();

        // Glitch: high 3 cycles, filtered out
        step(); btn_go_raw = 1'b1;
        step(); step(); step();
        btn_go_raw = 1'b0;
        repeat (12) step();

        // Resume PAUSE -> RUN
        clean_go(2'b01, 1'b1);

        // Both buttons together in RUN: clear wins
        step();
        btn_go_raw  = 1'b1;
        btn_clr_raw = 1'b1;
        expect_ev(cyc + 7, 2'b00, 1'b0, 1'b1);
        expect_ev(cyc + 8, 2'b00, 1'b0, 1'b0);
        release_and_settle();

        // Pause/resume from IDLE
        clean_go(2'b01, 1'b1);
        clean_go(2'b10, 1'b0);
        clean_go(2'b01, 1'b1);

        // Async reset mid-RUN and mid-debounce, button held through release
        step(); btn_go_raw = 1'b1;
        step(); step();
        clr_n = 1'b0;
        expect_ev(cyc, 2'b00, 1'b0, 1'b1);
        #1;
        chk("async_state", int'(state), 0);
        chk("async_go", int'(go), 0);
        chk("async_clr", int'(clr), 1);
        chk("async_led", int'(led_run), 0);
        step(); step();
        clr_n = 1'b1;
        m = cyc;
        expect_ev(m + 1, 2'b00, 1'b0, 1'b0);
        expect_ev(m + 7, 2'b01, 1'b1, 1'b0);
        release_and_settle();

        // Clear alone from RUN
        step();
        btn_clr_raw = 1'b1;
        expect_ev(cyc + 7, 2'b00, 1'b0, 1'b1);
        expect_ev(cyc + 8, 2'b00, 1'b0, 1'b0);
        release_and_settle();

        repeat (10) step();
        chk("pending_events", q.size(), 0);
        chk("final_state", int'(state), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
